ex_divider: RTL and testbench

Iterative RV32M divide/remainder unit in the execute stage. Takes DIV, DIVU, REM and REMU operands from the EX operand path and computes one quotient bit per cycle. It holds the pipeline through `ex_stall` while working. It presents a one-cycle result that the EX result mux forwards into the EX→MEM registers, in place of the ALU output, as `mem_alu`.

---
 rtl/ex_divider_if.sv | 34 +++
 rtl/ex_divider.sv | 131 +++++++++++++
 tb/tb_ex_divider.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ex_divider_if.sv
// rtl/ex_divider_if.sv - EX-stage divide unit request/response bundle
//
// Groups the divide request from the EX operand path and the result
// returned to the EX result mux.
//   start  : divide-class instruction occupies EX (held while it stays)
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b   : dividend and divisor (forwarded rs1/rs2)
//   kill   : flush of the EX instruction
//   busy   : stall request, ORed into ex_stall
//   done   : result valid this cycle
//   result : quotient or remainder
// master = EX pipeline side, slave = divider.
interface ex_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, b, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, kill,
    output busy, done, result
  );
endinterface

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-low reset
//   dif : ex_divider_if.slave (start/op/a/b/kill in, busy/done/result out)
// A request is latched in IDLE, iterated for WIDTH cycles in CALC using a
// restoring radix-2 loop on operand magnitudes, sign-corrected and shown
// for one cycle in DONE. Divide-by-zero and signed overflow skip CALC.
module ex_divider #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  ex_divider_if.slave dif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic             rem_sel;   // 1: return remainder, 0: quotient
  logic             neg_quo;   // operand signs differed (signed ops only)
  logic             neg_rem;   // dividend was negative (signed ops only)
  logic [WIDTH-1:0] part;      // partial remainder, always < divisor
  logic [WIDTH-1:0] quo;       // dividend bits shift out as quotient bits shift in
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;

  // Request decode, used only in IDLE
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_res;

  assign is_signed = ~dif.op[0];
  assign a_neg     = is_signed & dif.a[WIDTH-1];
  assign b_neg     = is_signed & dif.b[WIDTH-1];
  assign a_mag     = a_neg ? -dif.a : dif.a;
  assign b_mag     = b_neg ? -dif.b : dif.b;
  assign div_zero  = (dif.b == '0);
  assign overflow  = is_signed & (dif.a == MIN_NEG) & (dif.b == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = dif.op[1] ? dif.a : '1;
    end else begin
      special_res = dif.op[1] ? '0 : MIN_NEG;
    end
  end

  // One restoring step; the extra top bit of shifted keeps the trial exact
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] part_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign shifted = {part, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr};
  assign fits    = ~trial[WIDTH];
  assign part_nx = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx  = {quo[WIDTH-2:0], fits};
  assign quo_fix = neg_quo ? -quo_nx : quo_nx;
  assign rem_fix = neg_rem ? -part_nx : part_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      rem_sel  <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      part     <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (dif.kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (dif.start) begin
            rem_sel <= dif.op[1];
            if (div_zero || overflow) begin
              result_q <= special_res;
              state    <= S_DONE;
            end else begin
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              part    <= '0;
              quo     <= a_mag;
              dvsr    <= b_mag;
              cnt     <= '0;
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          part <= part_nx;
          quo  <= quo_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            result_q <= rem_sel ? rem_fix : quo_fix;
            state    <= S_DONE;
          end
        end
        // start is ignored here: the finishing instruction is still in EX
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dif.done   = (state == S_DONE);
  assign dif.result = result_q;
  assign dif.busy   = rst & ~dif.kill &
                      (((state == S_IDLE) & dif.start) | (state == S_CALC));
endmodule

// File: tb/tb_ex_divider.sv
// tb/tb_ex_divider.sv - scoreboard bench for ex_divider
module tb_ex_divider;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_divider_if #(.WIDTH(32)) dif();

  ex_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;
  logic [31:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    if (y == 32'd0) return o[1] ? x : 32'hffff_ffff;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hffff_ffff) return o[1] ? 32'd0 : 32'h8000_0000;
      return o[1] ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
    if (y == 32'd0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hffff_ffff) return 1;
    return 33;
  endfunction

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (dif.done) begin
      check("busy_low_in_done", {31'b0, dif.busy}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, dif.done}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("result", dif.result, mon_exp);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; returns just after the edge ending the DONE
  // cycle with start still high, so a following call is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input int chg_at);
    int n;
    int busy_n;
    dif.start = 1'b1;
    dif.op    = o;
    dif.a     = x;
    dif.b     = y;
    last_res  = ref_div(o, x, y);
    sb.push_back(last_res);
    n      = 0;
    busy_n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (dif.done) break;
      if (dif.busy) busy_n++;
      next_cycle();
      n++;
      if (n == chg_at) begin
        dif.a  = 32'h1234_5678;
        dif.b  = 32'd1;
        dif.op = 2'b00;
      end
    end
    check("latency", 32'(n), 32'(lat));
    check("busy_cycles", 32'(busy_n), 32'(lat));
    next_cycle();
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    rst       = 1'b0;
    dif.start = 1'b1;
    dif.op    = 2'b01;
    dif.a     = 32'd100;
    dif.b     = 32'd7;
    dif.kill  = 1'b0;
    @(negedge clk);
    check("busy_while_rst", {31'b0, dif.busy}, 32'd0);
    next_cycle();
    next_cycle();
    check("reset_done", {31'b0, dif.done}, 32'd0);
    check("reset_result", dif.result, 32'd0);
    check("reset_busy", {31'b0, dif.busy}, 32'd0);
    rst       = 1'b1;
    dif.start = 1'b0;
    next_cycle();

    run_op(2'b01, 32'd100, 32'd7, 33, 0);
    dif.start = 1'b0;
    next_cycle();
    run_op(2'b11, 32'd100, 32'd7, 33, 0);
    run_op(2'b00, 32'hffff_fff9, 32'd2, 33, 0);
    run_op(2'b10, 32'hffff_fff9, 32'd2, 33, 0);
    run_op(2'b10, 32'd7, 32'hffff_fffe, 33, 0);
    run_op(2'b00, 32'd5, 32'd0, 1, 0);
    run_op(2'b11, 32'd5, 32'd0, 1, 0);
    run_op(2'b00, 32'h8000_0000, 32'hffff_ffff, 1, 0);
    run_op(2'b10, 32'h8000_0000, 32'hffff_ffff, 1, 0);
    dif.start = 1'b0;
    next_cycle();

    // operand change mid-CALC, start held through DONE, then back-to-back
    run_op(2'b01, 32'd100, 32'd7, 33, 5);
    run_op(2'b01, 32'd9, 32'd3, 33, 0);
    dif.start = 1'b0;
    next_cycle();

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_op(ro, rx, ry, ref_lat(ro, rx, ry), 0);
    end
    dif.start = 1'b0;
    next_cycle();
    run_op(2'b01, 32'd9, 32'd3, 33, 0);
    dif.start = 1'b0;
    next_cycle();

    // kill in CALC cycle 10; a new request is accepted the next cycle
    dif.start = 1'b1;
    dif.op    = 2'b01;
    dif.a     = 32'd100;
    dif.b     = 32'd7;
    for (int i = 0; i < 10; i++) next_cycle();
    dif.kill = 1'b1;
    @(negedge clk);
    check("busy_on_kill", {31'b0, dif.busy}, 32'd0);
    next_cycle();
    dif.kill = 1'b0;
    check("kill_no_done", {31'b0, dif.done}, 32'd0);
    check("kill_result_held", dif.result, last_res);
    run_op(2'b01, 32'd9, 32'd3, 33, 0);
    dif.start = 1'b0;
    next_cycle();

    // reset mid-CALC
    dif.start = 1'b1;
    dif.op    = 2'b01;
    dif.a     = 32'd100;
    dif.b     = 32'd7;
    for (int i = 0; i < 20; i++) next_cycle();
    rst = 1'b0;
    next_cycle();
    check("rst_mid_done", {31'b0, dif.done}, 32'd0);
    check("rst_mid_result", dif.result, 32'd0);
    check("rst_mid_busy", {31'b0, dif.busy}, 32'd0);
    rst = 1'b1;
    run_op(2'b11, 32'd100, 32'd7, 33, 0);
    dif.start = 1'b0;

    for (int i = 0; i < 40; i++) next_cycle();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
